// File: rtl/regfile_sequencer_pkg.sv
// Shared types and defaults for the register-file command sequencer.
// Combinational only: no latency.
// No flow control: types, encodings and parameter defaults only.
package regfile_seq_pkg;

  localparam int DW_DEF = 16;  // register word width
  localparam int AW_DEF = 3;   // register index width (8 registers)

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_RSP  = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Command sequencer driving one read port and one write port of an 8xDW register file.
// Latency: WRITE 1 cycle, MOVE 2, SWAP 4, READ response valid in cycle 2 after acceptance.
// Backpressure: cmd_ready only in IDLE; READ result held in RSP until rsp_ready.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_op/cmd_ra/cmd_rb/cmd_imm fields
//   rsp_valid/rsp_ready/rsp_data     READ result channel
//   rf_writenum/rf_write/rf_data_in  register file write port (all registered)
//   rf_readnum/rf_data_out           register file read port (data_out combinational from readnum)
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [DW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_readnum,
  input  logic [DW-1:0] rf_data_out
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rb_q, rb_d;
  // t0 holds the first operand read; the second operand (t1) is loaded straight
  // into rf_data_in_q at the end of RD_B, since that is exactly the value WR_A writes.
  logic [DW-1:0] t0_q, t0_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rf_write_q, rf_write_d;
  logic [AW-1:0] rf_writenum_q, rf_writenum_d;
  logic [DW-1:0] rf_data_in_q, rf_data_in_d;
  logic [AW-1:0] rf_readnum_q, rf_readnum_d;

  logic          accept;
  op_e           cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);
  // cmd_ready_q (not state) gates acceptance so nothing is taken in the first
  // cycle after reset release, when cmd_ready is still low.
  assign accept   = cmd_valid && cmd_ready_q;

  // Every output is a flop: its next value is computed alongside the next state,
  // so the rf_* values for a state are already in place on the cycle it begins.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    t0_d          = t0_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rf_write_d    = 1'b0;
    rf_writenum_d = rf_writenum_q;
    rf_data_in_d  = rf_data_in_q;
    rf_readnum_d  = rf_readnum_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = cmd_op_e;
          ra_d = cmd_ra;
          rb_d = cmd_rb;
          if (cmd_op_e == OP_WRITE) begin
            state_d       = ST_WR_A;
            rf_write_d    = 1'b1;
            rf_writenum_d = cmd_ra;
            rf_data_in_d  = cmd_imm;
          end else begin
            state_d      = ST_RD_A;
            rf_readnum_d = cmd_ra;
          end
        end
      end

      ST_RD_A: begin
        t0_d = rf_data_out;
        unique case (op_q)
          OP_READ: begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rf_data_out;
          end
          OP_MOVE: begin
            state_d       = ST_WR_A;
            rf_write_d    = 1'b1;
            rf_writenum_d = rb_q;
            rf_data_in_d  = rf_data_out;
          end
          OP_SWAP: begin
            state_d      = ST_RD_B;
            rf_readnum_d = rb_q;
          end
          default: state_d = ST_IDLE;  // WRITE never reads
        endcase
      end

      ST_RD_B: begin
        state_d       = ST_WR_A;
        rf_write_d    = 1'b1;
        rf_writenum_d = ra_q;
        rf_data_in_d  = rf_data_out;
      end

      ST_WR_A: begin
        if (op_q == OP_SWAP) begin
          state_d       = ST_WR_B;
          rf_write_d    = 1'b1;
          rf_writenum_d = rb_q;
          rf_data_in_d  = t0_q;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_B: state_d = ST_IDLE;

      ST_RSP: begin
        // rsp_data_q is left untouched here, so it stays stable under backpressure.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_WRITE;
      ra_q          <= '0;
      rb_q          <= '0;
      t0_q          <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rf_write_q    <= 1'b0;
      rf_writenum_q <= '0;
      rf_data_in_q  <= '0;
      rf_readnum_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      t0_q          <= t0_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rf_write_q    <= rf_write_d;
      rf_writenum_q <= rf_writenum_d;
      rf_data_in_q  <= rf_data_in_d;
      rf_readnum_q  <= rf_readnum_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rf_write    = rf_write_q;
  assign rf_writenum = rf_writenum_q;
  assign rf_data_in  = rf_data_in_q;
  assign rf_readnum  = rf_readnum_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: an 8x16 register file responder plus a
// command-level reference model (register array updated per command).
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;

  logic [15:0] regs [8] = '{default: 16'h0};  // register file responder
  logic [15:0] mdl  [8] = '{default: 16'h0};  // expected register contents

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;
  assign rf_data_out = regs[rf_readnum];

  regfile_sequencer #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command starting from a negedge and follow it to completion.
  // hold = cycles rsp_ready stays low after rsp_valid rises (READ only).
  // chain = leave cmd_valid high so the next call is accepted with no gap.
  task automatic issue(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] imm, input int hold, input bit chain);
    logic [2:0]  exp_wn [2];
    logic [15:0] exp_wd [2];
    int n_wr, exp_busy, busy, wr_seen, rsp_first, rsp_cyc, guard;
    logic [15:0] exp_rsp;
    exp_wn = '{default: 3'd0};
    exp_wd = '{default: 16'h0};
    exp_rsp = 16'h0;
    n_wr = 0;
    exp_busy = 0;
    case (op)
      OP_WRITE: begin n_wr = 1; exp_wn[0] = ra; exp_wd[0] = imm; exp_busy = 1; end
      OP_READ:  begin exp_rsp = mdl[ra]; exp_busy = 2 + hold; end
      OP_MOVE:  begin n_wr = 1; exp_wn[0] = rb; exp_wd[0] = mdl[ra]; exp_busy = 2; end
      default: begin
        n_wr = 2; exp_busy = 4;
        exp_wn[0] = ra; exp_wd[0] = mdl[rb];
        exp_wn[1] = rb; exp_wd[1] = mdl[ra];
      end
    endcase

    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("ready_timeout", guard < 50, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);

    busy = 0; wr_seen = 0; rsp_first = 0; rsp_cyc = 0;
    while (!cmd_ready && busy < 64) begin
      busy++;
      // Fields are latched at acceptance; scramble them while busy.
      cmd_op = 2'($urandom); cmd_ra = 3'($urandom); cmd_rb = 3'($urandom);
      cmd_imm = 16'($urandom);
      if (rf_write) begin
        if (wr_seen < n_wr) begin
          chk("wr_num", rf_writenum, exp_wn[wr_seen]);
          chk("wr_data", rf_data_in, exp_wd[wr_seen]);
        end
        wr_seen++;
      end
      if (rsp_valid) begin
        if (rsp_first == 0) rsp_first = busy;
        rsp_cyc++;
        chk("rsp_data", rsp_data, exp_rsp);
      end
      rsp_ready = (op == OP_READ) && (busy == 2 + hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;

    chk("busy_cycles", busy, exp_busy);
    chk("write_pulses", wr_seen, n_wr);
    chk("rsp_cycles", rsp_cyc, (op == OP_READ) ? hold + 1 : 0);
    if (op == OP_READ) chk("rsp_latency", rsp_first, 2);
    chk("rsp_valid_after", rsp_valid, 0);

    case (op)
      OP_WRITE: mdl[ra] = imm;
      OP_MOVE:  mdl[rb] = mdl[ra];
      OP_SWAP:  begin exp_rsp = mdl[ra]; mdl[ra] = mdl[rb]; mdl[rb] = exp_rsp; end
      default: ;
    endcase
    if (!chain) cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ra = 3'd0; cmd_rb = 3'd0;
    cmd_imm = 16'h0; rsp_ready = 1'b0;

    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_writenum", rf_writenum, 0);
    chk("rst_readnum", rf_readnum, 0);
    chk("rst_data_in", rf_data_in, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // WRITE then READ
    issue(OP_WRITE, 3'd4, 3'd0, 16'h002A, 0, 0);
    issue(OP_READ,  3'd4, 3'd2, 16'h1234, 0, 0);
    // MOVE
    issue(OP_WRITE, 3'd1, 3'd5, 16'hBEEF, 0, 0);
    issue(OP_MOVE,  3'd1, 3'd6, 16'h5A5A, 0, 0);
    issue(OP_READ,  3'd6, 3'd0, 16'h0,    0, 0);
    issue(OP_READ,  3'd1, 3'd0, 16'h0,    0, 0);
    // SWAP
    issue(OP_WRITE, 3'd2, 3'd0, 16'h1111, 0, 0);
    issue(OP_WRITE, 3'd3, 3'd0, 16'h2222, 0, 0);
    issue(OP_SWAP,  3'd2, 3'd3, 16'hFFFF, 0, 0);
    issue(OP_READ,  3'd2, 3'd0, 16'h0,    0, 0);
    issue(OP_READ,  3'd3, 3'd0, 16'h0,    0, 0);
    // response backpressure
    issue(OP_READ,  3'd3, 3'd0, 16'h0,    5, 0);
    // same-register SWAP and back-to-back WRITE/READ with cmd_valid held
    issue(OP_WRITE, 3'd5, 3'd0, 16'h00FF, 0, 0);
    issue(OP_SWAP,  3'd5, 3'd5, 16'h0,    0, 0);
    issue(OP_READ,  3'd5, 3'd1, 16'h0,    0, 0);
    issue(OP_WRITE, 3'd0, 3'd0, 16'hC0DE, 0, 1);
    issue(OP_READ,  3'd0, 3'd0, 16'h0,    0, 0);

    // Reset during SWAP WR_B: Ra already updated, Rb write never lands.
    issue(OP_WRITE, 3'd6, 3'd0, 16'hAAAA, 0, 0);
    issue(OP_WRITE, 3'd7, 3'd0, 16'h5555, 0, 0);
    cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_ra = 3'd6; cmd_rb = 3'd7;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wrb_write", rf_write, 1);
    chk("wrb_num", rf_writenum, 7);
    chk("wrb_data", rf_data_in, 16'hAAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rf_write", rf_write, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_writenum", rf_writenum, 0);
    chk("arst_data_in", rf_data_in, 0);
    chk("arst_readnum", rf_readnum, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", cmd_ready, 1);
    mdl[6] = 16'h5555;
    issue(OP_READ, 3'd6, 3'd0, 16'h0, 0, 0);
    issue(OP_READ, 3'd7, 3'd0, 16'h0, 0, 0);

    // Random command stream
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 8; r++) chk($sformatf("final_r%0d", r), regs[r], mdl[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
